// File: rtl/ddr3_pkg.sv
// Shared types and constants for the DDR3 frame-buffer address scheduler.
package ddr3_pkg;

    localparam int unsigned ADDR_W    = 28;
    localparam int unsigned NUM_SLOTS = 3;
    localparam int unsigned IDX_W     = 2;

    localparam int unsigned DEF_FRAME_BURSTS = 3600;
    localparam int unsigned DEF_BURST_STEP   = 128;
    localparam int unsigned DEF_FRAME_STRIDE = 524288;
    localparam int unsigned DEF_GAP_CYCLES   = 2;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StWrIssue,
        StRdIssue,
        StGap
    } sched_state_e;

    // (idx + step) mod NUM_SLOTS for idx in 0..2 and step in 1..2
    function automatic logic [IDX_W-1:0] slot_add(input logic [IDX_W-1:0] idx,
                                                  input logic [IDX_W-1:0] step);
        logic [IDX_W:0] sum;
        sum = {1'b0, idx} + {1'b0, step};
        if (sum >= (IDX_W+1)'(NUM_SLOTS)) begin
            sum = sum - (IDX_W+1)'(NUM_SLOTS);
        end
        return sum[IDX_W-1:0];
    endfunction

    // All arithmetic stays in ADDR_W bits so it wraps modulo 2^28
    function automatic logic [ADDR_W-1:0] burst_addr(input logic [ADDR_W-1:0] base,
                                                     input logic [IDX_W-1:0]  idx,
                                                     input logic [ADDR_W-1:0] cnt,
                                                     input logic [ADDR_W-1:0] stride,
                                                     input logic [ADDR_W-1:0] step);
        return base + ADDR_W'(idx) * stride + cnt * step;
    endfunction

endpackage

// File: rtl/ddr3_frame_ptr.sv
// Triple-buffer slot selection: keeps the reader off the slot being written and
// hands the reader the most recently completed frame.
module ddr3_frame_ptr
    import ddr3_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_frame_start,
    input  logic             i_rd_frame_start,
    input  logic             i_wr_done,
    output logic [IDX_W-1:0] o_wr_idx,
    output logic [IDX_W-1:0] o_rd_idx
);

    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic [IDX_W-1:0] r_done_idx;
    logic             r_done_valid;

    logic [IDX_W-1:0] w_rd_idx_d;
    logic [IDX_W-1:0] w_wr_next;

    // Writer steps around the reader's slot as it will be after this cycle
    always_comb begin
        w_rd_idx_d = r_rd_idx;
        if (i_rd_frame_start && r_done_valid) begin
            w_rd_idx_d = r_done_idx;
        end
        w_wr_next = slot_add(r_wr_idx, 2'd1);
        if (w_wr_next == w_rd_idx_d) begin
            w_wr_next = slot_add(r_wr_idx, 2'd2);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_idx     <= '0;
            r_rd_idx     <= 2'd2;
            r_done_idx   <= '0;
            r_done_valid <= 1'b0;
        end else begin
            r_rd_idx <= w_rd_idx_d;
            if (i_wr_frame_start) begin
                r_wr_idx <= w_wr_next;
            end
            if (i_wr_done) begin
                r_done_idx   <= r_wr_idx;
                r_done_valid <= 1'b1;
            end
        end
    end

    assign o_wr_idx = r_wr_idx;
    assign o_rd_idx = r_rd_idx;

endmodule

// File: rtl/ddr3_frame_sched.sv
// Frame-buffer address scheduler: arbitrates write/read burst requests and pushes
// burst start addresses into the AXI write/read address FIFOs.
module ddr3_frame_sched
    import ddr3_pkg::*;
#(
    parameter int unsigned       FRAME_BURSTS = DEF_FRAME_BURSTS,
    parameter int unsigned       BURST_STEP   = DEF_BURST_STEP,
    parameter int unsigned       FRAME_STRIDE = DEF_FRAME_STRIDE,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int unsigned       GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic              i_clk_100M,
    input  logic              i_rst,
    input  logic              i_ddr_init_done,
    input  logic              i_wr_frame_start,
    input  logic              i_rd_frame_start,
    input  logic              i_wr_burst_req,
    input  logic              i_rd_burst_req,
    input  logic              i_awaddr_full,
    input  logic              i_araddr_full,
    output logic              o_awaddr_wr_en,
    output logic [ADDR_W-1:0] o_awaddr_din,
    output logic              o_araddr_wr_en,
    output logic [ADDR_W-1:0] o_araddr_din,
    output logic [IDX_W-1:0]  o_wr_frame_idx,
    output logic [IDX_W-1:0]  o_rd_frame_idx,
    output logic              o_wr_frame_done
);

    localparam int unsigned      CNT_W    = $clog2(FRAME_BURSTS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BURSTS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BURSTS - 1);
    localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES - 1);

    sched_state_e      r_state;
    sched_state_e      w_state_d;
    logic              r_init_done;
    logic              r_prior_wr;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [3:0]        r_gap_cnt;
    logic              r_aw_en;
    logic [ADDR_W-1:0] r_aw_din;
    logic              r_ar_en;
    logic [ADDR_W-1:0] r_ar_din;
    logic              r_wr_done;

    logic              w_wr_elig;
    logic              w_rd_elig;
    logic              w_grant_wr;
    logic              w_grant_rd;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_wr_elig = i_wr_burst_req && !i_awaddr_full && (r_wr_cnt < FULL_CNT);
    assign w_rd_elig = i_rd_burst_req && !i_araddr_full && (r_rd_cnt < FULL_CNT);

    assign w_wr_addr = burst_addr(BASE_ADDR, w_wr_idx, ADDR_W'(r_wr_cnt),
                                  ADDR_W'(FRAME_STRIDE), ADDR_W'(BURST_STEP));
    assign w_rd_addr = burst_addr(BASE_ADDR, w_rd_idx, ADDR_W'(r_rd_cnt),
                                  ADDR_W'(FRAME_STRIDE), ADDR_W'(BURST_STEP));

    always_comb begin
        w_state_d  = r_state;
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_init_done) begin
                    w_state_d = StArb;
                end
            end
            StArb: begin
                // A frame-start cycle never grants, so counters/indices settle first
                if (!i_wr_frame_start && !i_rd_frame_start) begin
                    if (w_wr_elig && (!w_rd_elig || r_prior_wr)) begin
                        w_grant_wr = 1'b1;
                        w_state_d  = StWrIssue;
                    end else if (w_rd_elig) begin
                        w_grant_rd = 1'b1;
                        w_state_d  = StRdIssue;
                    end
                end
            end
            StWrIssue, StRdIssue: begin
                w_state_d = StGap;
            end
            StGap: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_d = StArb;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk_100M or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_init_done <= 1'b0;
            r_prior_wr  <= 1'b1;
            r_gap_cnt   <= '0;
        end else begin
            r_state     <= w_state_d;
            r_init_done <= i_ddr_init_done;
            if (r_state == StWrIssue) begin
                r_prior_wr <= 1'b0;
            end else if (r_state == StRdIssue) begin
                r_prior_wr <= 1'b1;
            end
            if (r_state == StGap) begin
                r_gap_cnt <= r_gap_cnt + 4'd1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    // Frame-start reset wins over the increment of an in-flight push
    always_ff @(posedge i_clk_100M or posedge i_rst) begin
        if (i_rst) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (i_wr_frame_start) begin
                r_wr_cnt <= '0;
            end else if (r_state == StWrIssue) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
            if (i_rd_frame_start) begin
                r_rd_cnt <= '0;
            end else if (r_state == StRdIssue) begin
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk_100M or posedge i_rst) begin
        if (i_rst) begin
            r_aw_en   <= 1'b0;
            r_aw_din  <= '0;
            r_ar_en   <= 1'b0;
            r_ar_din  <= '0;
            r_wr_done <= 1'b0;
        end else begin
            r_aw_en   <= w_grant_wr;
            r_ar_en   <= w_grant_rd;
            r_wr_done <= w_grant_wr && (r_wr_cnt == LAST_CNT);
            if (w_grant_wr) begin
                r_aw_din <= w_wr_addr;
            end
            if (w_grant_rd) begin
                r_ar_din <= w_rd_addr;
            end
        end
    end

    ddr3_frame_ptr u_frame_ptr (
        .i_clk            (i_clk_100M),
        .i_rst            (i_rst),
        .i_wr_frame_start (i_wr_frame_start),
        .i_rd_frame_start (i_rd_frame_start),
        .i_wr_done        (r_wr_done),
        .o_wr_idx         (w_wr_idx),
        .o_rd_idx         (w_rd_idx)
    );

    assign o_awaddr_wr_en  = r_aw_en;
    assign o_awaddr_din    = r_aw_din;
    assign o_araddr_wr_en  = r_ar_en;
    assign o_araddr_din    = r_ar_din;
    assign o_wr_frame_idx  = w_wr_idx;
    assign o_rd_frame_idx  = w_rd_idx;
    assign o_wr_frame_done = r_wr_done;

endmodule
